// File: rtl/jump_pkg.sv
// Shared definitions for the jump trajectory datapath: state encoding,
// fixed-point formats, accumulator widths and the launch-velocity clamp.
`timescale 1ns/1ps
package jump_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_FLY    = 2'd2,
        ST_DONE   = 2'd3
    } jump_state_e;

    // Launch velocity limit and fixed-point fraction bits
    localparam int V_MAX       = 127;
    localparam int H_FRAC_BITS = 3;   // height accumulator in 1/8 px
    localparam int D_FRAC_BITS = 5;   // distance accumulator in 1/32 px

    // Datapath widths
    localparam int VIN_W    = 11;     // raw launch velocity from the game FSM
    localparam int V_W      = 7;      // clamped launch velocity
    localparam int VY_W     = 9;      // signed vertical velocity
    localparam int H_W      = 13;     // signed height accumulator
    localparam int D_W      = 14;     // unsigned distance accumulator
    localparam int DIST_W   = 11;     // published distance, px
    localparam int HEIGHT_W = 9;      // published height, px

    // Default vertical deceleration per step, 1/8 px
    localparam int GRAVITY_DEFAULT = 4;

    // Clamp the raw launch velocity into the 0..V_MAX range
    function automatic logic [V_W-1:0] sat_velocity(input logic [VIN_W-1:0] v);
        if (v > VIN_W'(V_MAX)) begin
            return V_W'(V_MAX);
        end
        return v[V_W-1:0];
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Trajectory step timebase: counts 0..STEP_DIV-1 while enabled and flags
// the terminal count for one cycle, which is the step tick.
`timescale 1ns/1ps
module step_prescaler #(
    parameter int STEP_DIV = 419_583
) (
    input  logic clk_machine,
    input  logic rst_machine,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] TERM = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          at_term;

    assign at_term = (cnt_q == TERM);

    // Free-running modulo counter, held while disabled, cleared on request
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= at_term ? '0 : cnt_q + CW'(1);
        end
    end

    // The tick is the last count of each period, so the first tick lands
    // exactly STEP_DIV cycles after the counter starts from zero
    assign o_tick = i_en && at_term;

endmodule

// File: rtl/jump_trajectory_ctrl.sv
// Jump trajectory controller: latches the launch velocity, steps a
// fixed-point ballistic arc on each prescaler tick and reports distance,
// height and landing to the game FSM and graphics path.
`timescale 1ns/1ps
module jump_trajectory_ctrl
    import jump_pkg::*;
#(
    parameter int STEP_DIV = 419_583,
    parameter int GRAVITY  = GRAVITY_DEFAULT
) (
    input  logic                clk_machine,
    input  logic                rst_machine,
    input  logic                i_jump_en,
    input  logic [VIN_W-1:0]    i_jump_v_init,
    output logic                o_jump_done,
    output logic [DIST_W-1:0]   o_jump_dist,
    output logic [HEIGHT_W-1:0] o_jump_height,
    output logic                o_busy
);

    localparam logic signed [VY_W-1:0] GRAV_VY = VY_W'(GRAVITY);

    jump_state_e               state_q;
    logic [V_W-1:0]            v_lat_q;
    logic signed [VY_W-1:0]    vy_q;
    logic signed [H_W-1:0]     h_acc_q;
    logic [D_W-1:0]            d_acc_q;
    logic                      done_q;
    logic                      busy_q;
    logic [DIST_W-1:0]         dist_q;
    logic [HEIGHT_W-1:0]       height_q;

    logic                      step_tick;
    logic                      presc_clr;
    logic                      presc_en;

    logic [V_W-1:0]            v_sat_d;
    logic signed [H_W-1:0]     h_acc_d;
    logic signed [VY_W-1:0]    vy_d;
    logic [D_W-1:0]            d_acc_d;
    logic                      landed_d;

    // Step timebase restarts on every launch and only runs during flight
    assign presc_clr = (state_q == ST_LAUNCH);
    assign presc_en  = (state_q == ST_FLY);

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_step_prescaler (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_clr       (presc_clr),
        .i_en        (presc_en),
        .o_tick      (step_tick)
    );

    // Candidate next values for one trajectory step
    always_comb begin
        v_sat_d  = sat_velocity(i_jump_v_init);
        h_acc_d  = h_acc_q + H_W'(vy_q);
        vy_d     = vy_q - GRAV_VY;
        d_acc_d  = d_acc_q + D_W'(v_lat_q);
        // Landing when the new height is zero or has gone below the block
        landed_d = h_acc_d[H_W-1] || (h_acc_d == '0);
    end

    // Controller FSM with the accumulators and registered outputs
    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            state_q  <= ST_IDLE;
            v_lat_q  <= '0;
            vy_q     <= '0;
            h_acc_q  <= '0;
            d_acc_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dist_q   <= '0;
            height_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q   <= 1'b0;
                    height_q <= '0;
                    if (i_jump_en) begin
                        // Clear the published arc on entry so the launch
                        // cycle already shows a fresh flight
                        state_q  <= ST_LAUNCH;
                        busy_q   <= 1'b1;
                        dist_q   <= '0;
                        h_acc_q  <= '0;
                        d_acc_q  <= '0;
                    end
                end

                ST_LAUNCH: begin
                    height_q <= '0;
                    if (!i_jump_en) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // Velocity is sampled only here; later changes on
                        // the input have no effect on this flight
                        v_lat_q <= v_sat_d;
                        vy_q    <= VY_W'(v_sat_d);
                        h_acc_q <= '0;
                        d_acc_q <= '0;
                        dist_q  <= '0;
                        state_q <= ST_FLY;
                    end
                end

                ST_FLY: begin
                    if (!i_jump_en) begin
                        // Abort: drop to the block, keep the distance reached
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        height_q <= '0;
                    end else if (step_tick) begin
                        vy_q    <= vy_d;
                        d_acc_q <= d_acc_d;
                        dist_q  <= DIST_W'(d_acc_d >> D_FRAC_BITS);
                        if (landed_d) begin
                            h_acc_q  <= '0;
                            height_q <= '0;
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            h_acc_q  <= h_acc_d;
                            height_q <= h_acc_d[H_FRAC_BITS +: HEIGHT_W];
                        end
                    end
                end

                ST_DONE: begin
                    // Hold the landing result until the FSM releases us
                    if (!i_jump_en) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    height_q <= '0;
                end
            endcase
        end
    end

    assign o_jump_done   = done_q;
    assign o_busy        = busy_q;
    assign o_jump_dist   = dist_q;
    assign o_jump_height = height_q;

endmodule
